// File: rtl/keypad_onehot_capture.sv
// keypad_onehot_capture: synchronize, debounce and capture a single pressed key as a one-hot code
module keypad_onehot_capture #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] keys_raw,
   output logic [15:0] key_onehot,
   output logic        key_valid,
   output logic        multi_err,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;
   localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);
   state_t      r_state, w_state;
   logic [15:0] r_s1, r_s2, r_sample, w_sample, r_cnt, w_cnt, r_onehot, w_onehot;
   logic        r_valid, w_valid, r_err, w_err, w_single;
   // sample is never zero when evaluated, so clearing the lowest set bit leaves zero only for one key
   assign w_single   = (r_sample & (r_sample - 16'd1)) == 16'd0;
   assign busy       = r_state != IDLE;
   assign key_onehot = r_onehot;
   assign key_valid  = r_valid;
   assign multi_err  = r_err;
   // 2-flop synchronizer, FSM state, counter, captured key and registered pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1     <= '0;
         r_s2     <= '0;
         r_state  <= IDLE;
         r_sample <= '0;
         r_cnt    <= '0;
         r_onehot <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_s1     <= keys_raw;
         r_s2     <= r_s1;
         r_state  <= w_state;
         r_sample <= w_sample;
         r_cnt    <= w_cnt;
         r_onehot <= w_onehot;
         r_valid  <= w_valid;
         r_err    <= w_err;
      end
   end
   // next-state: debounce a press, evaluate it once, then wait for a full debounced release
   always_comb begin
      w_state  = r_state;
      w_sample = r_sample;
      w_cnt    = r_cnt;
      w_onehot = r_onehot;
      w_valid  = 1'b0;
      w_err    = 1'b0;
      case (r_state)
         IDLE: if (r_s2 != 16'd0) begin
            w_state  = DEBOUNCE;
            w_sample = r_s2;
            w_cnt    = '0;
         end
         DEBOUNCE: if (r_s2 != r_sample) begin
            w_state = IDLE;
            w_cnt   = '0;
         end else if (r_cnt < LAST) begin
            w_cnt = r_cnt + 16'd1;
         end else begin
            w_state  = HELD;
            w_cnt    = '0;
            w_valid  = w_single;
            w_err    = !w_single;
            w_onehot = w_single ? r_sample : r_onehot;
         end
         HELD: if (r_s2 != 16'd0) begin
            w_cnt = '0;
         end else if (r_cnt < LAST) begin
            w_cnt = r_cnt + 16'd1;
         end else begin
            w_state = IDLE;
            w_cnt   = '0;
         end
         default: begin
            w_state = IDLE;
            w_cnt   = '0;
         end
      endcase
   end
endmodule
